alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
Multi-cycle 16x16 to 16-bit multiply controller that borrows the shared execute-stage ALU through a request/grant interface.
It performs shift-and-add multiplication:
- The ALU does the accumulate add (opcode 0000) and the multiplicand shift-left-logical (opcode 0101).
- The multiplier shift is done locally.
It sits beside the execute stage. The hazard/ALU-mux logic grants the ALU only when the pipeline is not using it.

Parameters:
ITER_MAX, 16, maximum shift-add iterations; width of the iteration counter is clog2(ITER_MAX)+1.
OP_ADD, 4'b0000, ALU opcode issued for accumulate.
OP_SLL, 4'b0101, ALU opcode issued for multiplicand shift.

Ports:
clk  in  1  clock; one clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
start  in  1  request a multiply; sampled only in IDLE
op_a  in  16  multiplicand, captured when start accepted
op_b  in  16  multiplier, captured when start accepted
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, product valid
product  out  16  low 16 bits of op_a*op_b; held until next accepted start
alu_req  out  1  sequencer needs the ALU this cycle
alu_gnt  in  1  ALU owned by sequencer this cycle (combinational from arbiter)
alu_a  out  16  ALU operand A; 0 when alu_req low
alu_b  out  16  ALU operand B; 0 when alu_req low
alu_op  out  4  ALU opcode; 0 when alu_req low
alu_result  in  16  ALU Result, combinational, same cycle as grant

Behaviour:
- Reset (sync):
  - state=IDLE; busy=0, done=0, product=0, alu_req=0, alu_a/b/op=0.
  - Internal acc, mcand, mplier and cnt all =0.
  - rst high mid-operation aborts and returns to IDLE next edge; no done pulse.
- FSM states: IDLE, ADD, SHL, DONE.
- IDLE:
  - On start=1: mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, next=ADD.
  - start while busy=1 is ignored (not queued).
- ADD:
  - If mplier[0]=0: next=SHL, no ALU request, 1 cycle.
  - If mplier[0]=1: alu_req=1, alu_op=OP_ADD, alu_a=acc, alu_b=mcand.
  - On alu_gnt=1: acc<=alu_result, next=SHL.
  - On alu_gnt=0: hold state; outputs stable.
- SHL:
  - alu_req=1, alu_op=OP_SLL, alu_a=mcand, alu_b=16'h0001.
  - On alu_gnt=1: mcand<=alu_result, mplier<=mplier>>1 (zero fill), cnt<=cnt+1.
  - Next=DONE if cnt==ITER_MAX-1, else ADD.
  - On alu_gnt=0: hold everything.
- DONE:
  - done=1, product<=acc (visible the same cycle via registered acc path), next=IDLE.
  - busy=1 in DONE.
- Arithmetic: all 16-bit modulo 2^16. Overflow and carry are discarded. The result is identical for signed and unsigned operands.
- Latency, alu_gnt always 1, macro off: start accepted at edge E; ADD/SHL occupy 2*ITER_MAX cycles; done high in cycle E+2*ITER_MAX+1 (33 for default).
- Stalls: each cycle with alu_req=1 and alu_gnt=0 adds exactly one cycle.
- alu_gnt while alu_req=0 is ignored.

Optional Feature:
Macro MUL_EARLY_TERM_EN.
- Defined: in SHL, on grant, if (mplier>>1)==0 go to DONE regardless of cnt.
  - op_b=0 goes IDLE->ADD->SHL->DONE (SHL still issued once).
  - Latency = 2*(index of highest set bit of op_b + 1) ADD/SHL cycles.
- Undefined: always ITER_MAX iterations; latency fixed, data-independent.

Decomposition:
- Shared header/package: the ALU opcode constants (OP_ADD, OP_SLL, plus the full 4-bit ALU opcode set) and the FSM state encoding.
- Both the ALU and this block include it.
- No sub-module is natural; FSM, counter and datapath registers stay in one module.

Test Plan:
1. op_a=3, op_b=5, alu_gnt=1 always, macro off -> product=16'h000F, done pulse exactly 33 cycles after start edge, busy high throughout.
2. Same stimulus, MUL_EARLY_TERM_EN defined -> product=16'h000F after 3 iterations (6 ADD/SHL cycles); op_b=0 -> product=0 after 1 iteration.
3. op_a=16'hFFFF, op_b=16'hFFFF -> product=16'h0001; op_a=16'h8000, op_b=2 -> product=16'h0000 (wrap).
4. During a SHL, hold alu_gnt=0 for 5 cycles -> alu_req, alu_a, alu_b and alu_op stable, mcand/cnt unchanged; done delayed exactly 5 cycles; product still correct.
5. Pulse start with op_a=9 while busy -> ignored; in-flight product unchanged; next start after done accepted normally.
6. Assert rst mid-ADD -> next cycle busy=0, alu_req=0, product=0, no done pulse; a new start then completes correctly.

Source files
------------

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the execute-stage ALU and the multiply sequencer:
// the full 4-bit ALU opcode set and the sequencer FSM state encoding.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SHL  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16->16 multiplier that borrows the shared ALU via req/gnt.
// Optional macro MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier is zero.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int ITER_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result
);

  localparam int CNT_W = $clog2(ITER_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_MAX - 1);

  seq_state_e       state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      mcand_q, mcand_d;
  logic [15:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic [15:0]      aluA_q, aluA_d;
  logic [15:0]      aluB_q, aluB_d;
  logic [3:0]       aluOp_q, aluOp_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        if (!mplier_q[0]) begin
          state_d = ST_SHL;
        end else if (alu_gnt) begin
          acc_d   = alu_result;
          state_d = ST_SHL;
        end
      end
      ST_SHL: begin
        if (alu_gnt) begin
          mcand_d  = alu_result;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
`ifdef MUL_EARLY_TERM_EN
          if ((cnt_q == CNT_LAST) || (mplier_d == 16'h0000)) state_d = ST_DONE;
          else                                                state_d = ST_ADD;
`else
          if (cnt_q == CNT_LAST) state_d = ST_DONE;
          else                   state_d = ST_ADD;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) product_d = acc_d;

    // Outputs are registered from the next-state values so the ALU sees glitch-free operands.
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    req_d   = 1'b0;
    aluA_d  = '0;
    aluB_d  = '0;
    aluOp_d = '0;
    if (state_d == ST_ADD && mplier_d[0]) begin
      req_d   = 1'b1;
      aluA_d  = acc_d;
      aluB_d  = mcand_d;
      aluOp_d = OP_ADD;
    end else if (state_d == ST_SHL) begin
      req_d   = 1'b1;
      aluA_d  = mcand_d;
      aluB_d  = 16'h0001;
      aluOp_d = OP_SLL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluOp_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      req_q     <= req_d;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      aluOp_q   <= aluOp_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign alu_req = req_q;
  assign alu_a   = aluA_q;
  assign alu_b   = aluB_q;
  assign alu_op  = aluOp_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a small behavioural model of the shared ALU.
// Expected latencies follow MUL_EARLY_TERM_EN when the bench is built with it.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        alu_req;
  logic        alu_gnt;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    int          cyc;
    int          cycEarly;
  } vec_t;

  vec_t vecs[9];

  alu_mul_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared execute-stage ALU stand-in; only the two opcodes the sequencer uses matter.
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SLL:  alu_result = alu_a << alu_b[3:0];
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int expLatency(input vec_t v);
`ifdef MUL_EARLY_TERM_EN
    return v.cycEarly;
`else
    return v.cyc;
`endif
  endfunction

  // Runs one multiply from IDLE; optional grant stall on the first SHL and a stray start at cycle injAt.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int stallN, input int injAt,
                               output int cycles, output logic [15:0] prod, output logic busyOk,
                               output logic stallOk);
    logic        stalled;
    logic [15:0] ra, rb;
    logic [3:0]  ro;
    stalled = 1'b0;
    stallOk = 1'b1;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    busyOk = (busy === 1'b1);
    while (done !== 1'b1 && cycles < 200) begin
      if (stallN > 0 && !stalled && alu_req === 1'b1 && alu_op === OP_SLL) begin
        stalled = 1'b1;
        ra = alu_a;
        rb = alu_b;
        ro = alu_op;
        alu_gnt = 1'b0;
        for (int i = 0; i < stallN; i++) begin
          @(posedge clk); #1;
          cycles++;
          if (alu_req !== 1'b1 || alu_a !== ra || alu_b !== rb || alu_op !== ro) stallOk = 1'b0;
          if (busy !== 1'b1) busyOk = 1'b0;
        end
        alu_gnt = 1'b1;
      end else begin
        if (cycles == injAt) begin
          start = 1'b1;
          op_a  = 16'd9;
          op_b  = 16'd7;
        end
        @(posedge clk); #1;
        start = 1'b0;
        cycles++;
        if (busy !== 1'b1) busyOk = 1'b0;
      end
    end
    prod = product;
  endtask

  task automatic checkReturnToIdle(input string name);
    @(posedge clk); #1;
    checkOutput(name, {30'd0, done, busy}, 32'd0);
  endtask

  int          cycles;
  logic [15:0] prod;
  logic        busyOk;
  logic        stallOk;
  int          base35;
  logic        sawDone;

  initial begin
    vecs[0] = '{a: 16'h0003, b: 16'h0005, prod: 16'h000F, cyc: 33, cycEarly: 7};
    vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, prod: 16'h0001, cyc: 33, cycEarly: 33};
    vecs[2] = '{a: 16'h8000, b: 16'h0002, prod: 16'h0000, cyc: 33, cycEarly: 5};
    vecs[3] = '{a: 16'h1234, b: 16'h0000, prod: 16'h0000, cyc: 33, cycEarly: 3};
    vecs[4] = '{a: 16'h0000, b: 16'h1234, prod: 16'h0000, cyc: 33, cycEarly: 27};
    vecs[5] = '{a: 16'h00FF, b: 16'h0101, prod: 16'hFFFF, cyc: 33, cycEarly: 19};
    vecs[6] = '{a: 16'h0007, b: 16'h0009, prod: 16'h003F, cyc: 33, cycEarly: 9};
    vecs[7] = '{a: 16'h1234, b: 16'h5678, prod: 16'h0060, cyc: 33, cycEarly: 31};
    vecs[8] = '{a: 16'hFFFF, b: 16'h0003, prod: 16'hFFFD, cyc: 33, cycEarly: 5};

    rst     = 1'b1;
    start   = 1'b0;
    op_a    = 16'h0000;
    op_b    = 16'h0000;
    alu_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBusy",    {31'd0, busy},    32'd0);
    checkOutput("rstDone",    {31'd0, done},    32'd0);
    checkOutput("rstProduct", {16'd0, product}, 32'd0);
    checkOutput("rstReq",     {31'd0, alu_req}, 32'd0);
    checkOutput("rstAluA",    {16'd0, alu_a},   32'd0);
    checkOutput("rstAluB",    {16'd0, alu_b},   32'd0);
    checkOutput("rstAluOp",   {28'd0, alu_op},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // First two ALU requests of 3*5: accumulate 0+3, then shift 3 left by one.
    start = 1'b1;
    op_a  = 16'd3;
    op_b  = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("addReq",  {31'd0, alu_req}, 32'd1);
    checkOutput("addOpA",  {16'd0, alu_a},   32'd0);
    checkOutput("addOpB",  {16'd0, alu_b},   32'd3);
    checkOutput("addCode", {28'd0, alu_op},  {28'd0, OP_ADD});
    @(posedge clk); #1;
    checkOutput("shlReq",  {31'd0, alu_req}, 32'd1);
    checkOutput("shlOpA",  {16'd0, alu_a},   32'd3);
    checkOutput("shlOpB",  {16'd0, alu_b},   32'd1);
    checkOutput("shlCode", {28'd0, alu_op},  {28'd0, OP_SLL});
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("firstIdle", {31'd0, busy}, 32'd0);
      checkOutput("firstProd", {16'd0, product}, 32'h000F);
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 0, -1, cycles, prod, busyOk, stallOk);
      checkOutput($sformatf("product[%0d]", i), {16'd0, prod}, {16'd0, vecs[i].prod});
      checkOutput($sformatf("latency[%0d]", i), cycles, expLatency(vecs[i]));
      checkOutput($sformatf("busyHeld[%0d]", i), {31'd0, busyOk}, 32'd1);
      checkReturnToIdle($sformatf("donePulse[%0d]", i));
    end

    base35 = expLatency(vecs[0]);

    applyStimulus(16'd3, 16'd5, 5, -1, cycles, prod, busyOk, stallOk);
    checkOutput("stallProduct", {16'd0, prod}, 32'h000F);
    checkOutput("stallLatency", cycles, base35 + 5);
    checkOutput("stallStable",  {31'd0, stallOk}, 32'd1);
    checkOutput("stallBusy",    {31'd0, busyOk}, 32'd1);
    checkReturnToIdle("stallDonePulse");

    applyStimulus(16'd3, 16'd5, 0, 3, cycles, prod, busyOk, stallOk);
    checkOutput("ignoreStartProduct", {16'd0, prod}, 32'h000F);
    checkOutput("ignoreStartLatency", cycles, base35);
    checkReturnToIdle("ignoreStartIdle");
    applyStimulus(16'd9, 16'd7, 0, -1, cycles, prod, busyOk, stallOk);
    checkOutput("nextStartProduct", {16'd0, prod}, 32'h003F);

    // Abort during the first ADD; the previous product must be wiped and no done may follow.
    @(posedge clk); #1;
    start = 1'b1;
    op_a  = 16'd3;
    op_b  = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abortBusy",    {31'd0, busy},    32'd0);
    checkOutput("abortReq",     {31'd0, alu_req}, 32'd0);
    checkOutput("abortProduct", {16'd0, product}, 32'd0);
    checkOutput("abortDone",    {31'd0, done},    32'd0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abortQuiet", {31'd0, sawDone}, 32'd0);
    applyStimulus(16'd3, 16'd5, 0, -1, cycles, prod, busyOk, stallOk);
    checkOutput("afterAbortProduct", {16'd0, prod}, 32'h000F);
    checkOutput("afterAbortLatency", cycles, base35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
